ex_alu_stage: RTL and testbench
===============================

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 32, meaning operand/result width.
REQ-002 The module SHALL have parameter NB_ALU_OP, default 4, meaning ALU operation code width, matching the alu_control output.
REQ-003 The module SHALL have parameter NB_SHAMT, default 5, meaning shift amount width.
REQ-004 The module SHALL have parameter NB_REG, default 5, meaning destination register index width.
REQ-005 Ports SHALL be:
 i_clk  input  1  single clock; all state on rising edge
 i_reset  input  1  asynchronous, active-high reset
 i_valid  input  1  upstream operation valid
 o_ready  output  1  stage can accept an operation
 i_alu_operation  input  NB_ALU_OP  operation code from alu_control
 i_operand_a  input  NB_DATA  first operand (rs)
 i_operand_b  input  NB_DATA  second operand (rt or extended immediate)
 i_shamt  input  NB_SHAMT  shift amount
 i_write_reg  input  NB_REG  destination register index
 i_reg_write  input  1  register-write control bit
 i_flush  input  1  synchronous discard of all held entries
 o_valid  output  1  result available downstream
 i_ready  input  1  downstream accepts result
 o_result  output  NB_DATA  ALU result
 o_zero  output  1  o_result equals zero
 o_write_reg  output  NB_REG  forwarded destination index
 o_reg_write  output  1  forwarded register-write bit

Function
REQ-006 Operation codes SHALL be the ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA codes from the execute constants header.
REQ-007 ADD/SUB SHALL compute A+B / A-B modulo 2^NB_DATA; no overflow flag, no trap.
REQ-008 AND/OR/XOR/NOR SHALL be bitwise on A and B.
REQ-009 SLT SHALL yield 1 when A < B as signed two's complement, else 0, zero-extended.
REQ-010 SLL/SRL/SRA SHALL shift B by i_shamt; SRA replicates B's MSB.
REQ-011 Any code not listed in REQ-006 (including the alu_control default 0 if unassigned) SHALL yield result 0.
REQ-012 The stage SHALL hold up to 2 entries (output register + skid register); state EMPTY(0), ONE(1), FULL(2).
REQ-013 An input transfer SHALL occur when i_valid && o_ready on a rising edge; an output transfer when o_valid && i_ready.
REQ-014 Result, zero flag, i_write_reg and i_reg_write SHALL be computed and captured at the input transfer edge; latency is 1 cycle (o_valid high the cycle after acceptance when EMPTY).
REQ-015 o_ready SHALL be a registered signal equal to (state != FULL); it SHALL NOT depend combinationally on i_ready.
REQ-016 Transitions: EMPTY+in -> ONE; ONE+in, no out -> FULL (new entry to skid); ONE+in+out -> ONE (new entry to output); ONE+out -> EMPTY; FULL+out -> ONE (skid moves to output); FULL without out -> FULL.
REQ-017 Output fields SHALL remain stable while o_valid && !i_ready.
REQ-018 Entries SHALL leave in acceptance order; none duplicated or dropped.
REQ-019 i_flush SHALL have priority: next state EMPTY, o_valid 0, o_ready 1; an input presented in the flush cycle SHALL be discarded; an output handshake in the flush cycle counts as completed.
REQ-020 o_zero SHALL equal (o_result == 0) for the held entry.

Reset
REQ-021 Asserting i_reset SHALL immediately, asynchronously force state EMPTY, o_valid 0, o_result 0, o_zero 0, o_write_reg 0, o_reg_write 0, skid contents 0.
REQ-022 o_ready SHALL be 0 while i_reset is high and 1 on the first clock edge after release.
REQ-023 Reset mid-operation SHALL discard all held entries without emitting them.

Verification
REQ-024 ADD A=0x7FFFFFFF, B=1, i_ready=1 -> next cycle o_valid=1, o_result=0x80000000, o_zero=0.
REQ-025 SLT A=0xFFFFFFFF, B=1 -> o_result=1; SRA B=0x80000000, shamt=4 -> 0xF8000000; SUB A=B=5 -> o_result=0, o_zero=1.
REQ-026 i_ready=0, send ops X then Y -> o_ready 0 after Y; raise i_ready -> X then Y emitted in consecutive cycles, o_ready returns to 1.
REQ-027 FULL state, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1; the flush-cycle input never appears.
REQ-028 FULL state, assert i_reset between edges -> o_valid drops to 0 before the next edge; after release first accepted op emerges with correct result.
REQ-029 Random valid/ready/flush stream (≥10k ops) vs reference model -> identical ordered result, zero flag, write_reg and reg_write sequence.

Source files
------------

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute-stage ALU with a two-entry output/skid buffer
// Results are computed at input acceptance; the skid register absorbs one extra op when downstream stalls.
module ex_alu_stage #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 4,
  parameter int NB_SHAMT  = 5,
  parameter int NB_REG    = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NB_ALU_OP-1:0] i_alu_operation,
  input  logic [NB_DATA-1:0]   i_operand_a,
  input  logic [NB_DATA-1:0]   i_operand_b,
  input  logic [NB_SHAMT-1:0]  i_shamt,
  input  logic [NB_REG-1:0]    i_write_reg,
  input  logic                 i_reg_write,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_zero,
  output logic [NB_REG-1:0]    o_write_reg,
  output logic                 o_reg_write
);

  localparam logic [NB_ALU_OP-1:0] ALU_ADD = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] ALU_SUB = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] ALU_AND = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] ALU_OR  = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] ALU_XOR = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] ALU_NOR = NB_ALU_OP'(6);
  localparam logic [NB_ALU_OP-1:0] ALU_SLT = NB_ALU_OP'(7);
  localparam logic [NB_ALU_OP-1:0] ALU_SLL = NB_ALU_OP'(8);
  localparam logic [NB_ALU_OP-1:0] ALU_SRL = NB_ALU_OP'(9);
  localparam logic [NB_ALU_OP-1:0] ALU_SRA = NB_ALU_OP'(10);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]         state, state_nxt;
  logic               ready_q;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_zero;
  logic               in_xfer, out_xfer;
  logic               load_out, load_skid, skid_to_out;

  logic [NB_DATA-1:0] skid_result;
  logic               skid_zero;
  logic [NB_REG-1:0]  skid_write_reg;
  logic               skid_reg_write;

  always_comb begin
    alu_res = '0;
    case (i_alu_operation)
      ALU_ADD: alu_res = i_operand_a + i_operand_b;
      ALU_SUB: alu_res = i_operand_a - i_operand_b;
      ALU_AND: alu_res = i_operand_a & i_operand_b;
      ALU_OR:  alu_res = i_operand_a | i_operand_b;
      ALU_XOR: alu_res = i_operand_a ^ i_operand_b;
      ALU_NOR: alu_res = ~(i_operand_a | i_operand_b);
      ALU_SLT: alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
      ALU_SLL: alu_res = i_operand_b << i_shamt;
      ALU_SRL: alu_res = i_operand_b >> i_shamt;
      ALU_SRA: alu_res = $unsigned($signed(i_operand_b) >>> i_shamt);
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign o_ready  = ready_q;
  assign o_valid  = (state != ST_EMPTY);
  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = o_valid && i_ready;

  // Flush wins over everything; an input in the flush cycle is dropped.
  always_comb begin
    state_nxt   = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (i_flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) begin
          load_out  = 1'b1;
          state_nxt = ST_ONE;
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            load_out = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: if (out_xfer) begin
          skid_to_out = 1'b1;
          state_nxt   = ST_ONE;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_EMPTY;
      ready_q        <= 1'b0;
      o_result       <= '0;
      o_zero         <= 1'b0;
      o_write_reg    <= '0;
      o_reg_write    <= 1'b0;
      skid_result    <= '0;
      skid_zero      <= 1'b0;
      skid_write_reg <= '0;
      skid_reg_write <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_FULL);
      if (load_out) begin
        o_result    <= alu_res;
        o_zero      <= alu_zero;
        o_write_reg <= i_write_reg;
        o_reg_write <= i_reg_write;
      end else if (skid_to_out) begin
        o_result    <= skid_result;
        o_zero      <= skid_zero;
        o_write_reg <= skid_write_reg;
        o_reg_write <= skid_reg_write;
      end
      if (load_skid) begin
        skid_result    <= alu_res;
        skid_zero      <= alu_zero;
        skid_write_reg <= i_write_reg;
        skid_reg_write <= i_reg_write;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - scoreboard bench for ex_alu_stage
// Vector table, handshake corner sequences and a long random valid/ready/flush stream.
module tb_ex_alu_stage;

  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                         OP_XOR = 4'd5, OP_NOR = 4'd6, OP_SLT = 4'd7, OP_SLL = 4'd8,
                         OP_SRL = 4'd9, OP_SRA = 4'd10;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_alu_operation = '0;
  logic [31:0] i_operand_a = '0;
  logic [31:0] i_operand_b = '0;
  logic [4:0]  i_shamt = '0;
  logic [4:0]  i_write_reg = '0;
  logic        i_reg_write = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_zero;
  logic [4:0]  o_write_reg;
  logic        o_reg_write;

  ex_alu_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_operation(i_alu_operation), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_shamt(i_shamt), .i_write_reg(i_write_reg), .i_reg_write(i_reg_write), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero),
    .o_write_reg(o_write_reg), .o_reg_write(o_reg_write)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  wreg;
    logic        rw;
  } ent_t;

  ent_t        q[$];
  logic [31:0] cur_exp = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return b << sh;
      OP_SRL:  return b >> sh;
      OP_SRA:  return $unsigned($signed(b) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard: the queue holds exactly the entries the stage should be holding.
  always @(negedge i_clk) begin
    if (i_reset) begin
      q.delete();
    end else begin
      if (o_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got result %h with no entry outstanding", o_result);
        end else begin
          chk("result", o_result, q[0].result);
          chk("zero", {31'd0, o_zero}, {31'd0, (q[0].result == 32'd0)});
          chk("write_reg", {27'd0, o_write_reg}, {27'd0, q[0].wreg});
          chk("reg_write", {31'd0, o_reg_write}, {31'd0, q[0].rw});
          if (i_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (i_flush) begin
        q.delete();
      end else if (i_valid && o_ready) begin
        q.push_back('{cur_exp, i_write_reg, i_reg_write});
        n_acc++;
      end
    end
  end

  // Presents one op and returns at posedge+1 after it has been accepted.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [4:0] wr, input logic rw,
                      input logic [31:0] exp);
    logic ok;
    i_alu_operation = op; i_operand_a = a; i_operand_b = b; i_shamt = sh;
    i_write_reg = wr; i_reg_write = rw; cur_exp = exp; i_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge i_clk);
      ok = o_ready && !i_flush;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got o_ready=%b expected 1 within 50 cycles", o_ready);
    end
  endtask

  vec_t tab[18];

  initial begin
    tab[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000};
    tab[1]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
    tab[2]  = '{OP_SRA, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000};
    tab[3]  = '{OP_SUB, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000};
    tab[4]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
    tab[5]  = '{OP_SUB, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF};
    tab[6]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000};
    tab[7]  = '{OP_OR,  32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0};
    tab[8]  = '{OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F};
    tab[9]  = '{OP_NOR, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF};
    tab[10] = '{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000};
    tab[11] = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001};
    tab[12] = '{OP_SLL, 32'hDEADBEEF, 32'h00000001, 5'd31, 32'h80000000};
    tab[13] = '{OP_SRL, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001};
    tab[14] = '{OP_SRA, 32'h00000000, 32'h7FFFFFF0, 5'd4,  32'h07FFFFFF};
    tab[15] = '{4'd0,   32'h00000001, 32'h00000002, 5'd3,  32'h00000000};
    tab[16] = '{4'd15,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000};
    tab[17] = '{OP_SLL, 32'h00000000, 32'h12345678, 5'd0,  32'h12345678};

    // Reset state
    #2;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_o_result", o_result, 32'd0);
    chk("rst_o_zero", {31'd0, o_zero}, 32'd0);
    chk("rst_o_write_reg", {27'd0, o_write_reg}, 32'd0);
    chk("rst_o_reg_write", {31'd0, o_reg_write}, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("rst_release_ready_low", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    chk("first_edge_ready", {31'd0, o_ready}, 32'd1);

    // Vector table, downstream always ready: each result appears one cycle after acceptance
    i_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      send(tab[i].op, tab[i].a, tab[i].b, tab[i].sh, 5'(i), i[0], tab[i].exp);
      chk("latency_valid", {31'd0, o_valid}, 32'd1);
    end
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("table_drained", {31'd0, o_valid}, 32'd0);

    // Stall: X then Y fill the buffer, then drain in order on consecutive cycles
    i_ready = 1'b0;
    send(OP_ADD, 32'd3, 32'd4, 5'd0, 5'd7, 1'b1, 32'd7);
    chk("one_ready", {31'd0, o_ready}, 32'd1);
    send(OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 5'd9, 1'b0, 32'h55555555);
    chk("full_ready", {31'd0, o_ready}, 32'd0);
    @(posedge i_clk); #1;
    chk("full_hold_ready", {31'd0, o_ready}, 32'd0);
    chk("full_hold_result", o_result, 32'd7);
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("drain_x_valid", {31'd0, o_valid}, 32'd1);
    chk("drain_x_result", o_result, 32'd7);
    @(negedge i_clk);
    chk("drain_y_valid", {31'd0, o_valid}, 32'd1);
    chk("drain_y_result", o_result, 32'h55555555);
    @(posedge i_clk); #1;
    chk("drain_ready", {31'd0, o_ready}, 32'd1);
    chk("drain_empty", {31'd0, o_valid}, 32'd0);

    // Flush while FULL with a competing input
    i_ready = 1'b0;
    send(OP_OR, 32'h1, 32'h2, 5'd0, 5'd1, 1'b1, 32'h3);
    send(OP_OR, 32'h4, 32'h8, 5'd0, 5'd2, 1'b1, 32'hC);
    i_flush = 1'b1;
    i_valid = 1'b1; i_alu_operation = OP_ADD; i_operand_a = 32'h11; i_operand_b = 32'h22;
    cur_exp = 32'h33;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("flush_no_output", {31'd0, o_valid}, 32'd0);

    // Asynchronous reset while FULL
    i_ready = 1'b0;
    send(OP_SUB, 32'd9, 32'd2, 5'd0, 5'd3, 1'b1, 32'd7);
    send(OP_SUB, 32'd9, 32'd4, 5'd0, 5'd4, 1'b1, 32'd5);
    #1 i_reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, o_ready}, 32'd0);
    chk("async_rst_result", o_result, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    send(OP_NOR, 32'hFFFF0000, 32'h0000FF00, 5'd0, 5'd5, 1'b0, 32'h000000FF);
    chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
    chk("post_rst_result", o_result, 32'h000000FF);
    @(posedge i_clk); #1;

    // Random stream against the scoreboard
    begin
      int base;
      base = n_acc;
      for (int c = 0; c < 60000 && (n_acc - base) < 10000; c++) begin
        i_valid         = ($urandom_range(3) != 0);
        i_ready         = ($urandom_range(3) != 0);
        i_flush         = ($urandom_range(99) == 0);
        i_alu_operation = 4'($urandom_range(15));
        i_operand_a     = $urandom;
        i_operand_b     = ($urandom_range(7) == 0) ? i_operand_a : $urandom;
        i_shamt         = 5'($urandom_range(31));
        i_write_reg     = 5'($urandom_range(31));
        i_reg_write     = 1'($urandom_range(1));
        cur_exp         = alu_model(i_alu_operation, i_operand_a, i_operand_b, i_shamt);
        @(posedge i_clk); #1;
      end
      i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;
      chk("random_ops_accepted", {31'd0, (n_acc - base) >= 10000}, 32'd1);
      chk("random_queue_empty", q.size(), 32'd0);
      chk("random_drained", {31'd0, o_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
